// File: rtl/wb_data_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_data_arbiter
//  Description : Three-master Wishbone classic arbiter in front of a single
//                data RAM slave. Round-robin grant, one transaction per
//                grant, slave-ack timeout with error return, and one dead
//                cycle after every transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_data_arbiter #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,

    // Master 0
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [DW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [DW-1:0] m0_dat_o,

    // Master 1
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [DW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [DW-1:0] m1_dat_o,

    // Master 2
    input  logic          m2_cyc_i,
    input  logic          m2_stb_i,
    input  logic          m2_we_i,
    input  logic [DW-1:0] m2_adr_i,
    input  logic [DW-1:0] m2_dat_i,
    output logic          m2_ack_o,
    output logic          m2_err_o,
    output logic [DW-1:0] m2_dat_o,

    // Shared slave (data RAM)
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [DW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    input  logic          ack_i,
    input  logic [DW-1:0] dat_i,

    // Current grant index, 3 = none
    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] NO_GNT      = 2'd3;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  gnt_q,   gnt_d;
    logic [1:0]  last_q,  last_d;
    logic [7:0]  wcnt_q,  wcnt_d;

    // Bit 3 is a permanently-empty slot so a 2-bit index never leaves range
    logic [3:0]    w_req;
    logic [1:0]    w_ord0, w_ord1, w_ord2;
    logic [1:0]    w_win;
    logic          w_win_vld;

    logic          w_sel_cyc;
    logic          w_sel_we;
    logic [DW-1:0] w_sel_adr;
    logic [DW-1:0] w_sel_dat;

    logic          w_busy;
    logic          w_fire_ack;
    logic          w_fire_err;
    logic [2:0]    w_gnt_dec;

    assign w_req = {1'b0,
                    m2_cyc_i & m2_stb_i,
                    m1_cyc_i & m1_stb_i,
                    m0_cyc_i & m0_stb_i};

    // Search order starts just after the last master served
    always_comb begin
        w_ord0 = 2'd0;
        w_ord1 = 2'd1;
        w_ord2 = 2'd2;
        case (last_q)
            2'd0: begin
                w_ord0 = 2'd1;
                w_ord1 = 2'd2;
                w_ord2 = 2'd0;
            end
            2'd1: begin
                w_ord0 = 2'd2;
                w_ord1 = 2'd0;
                w_ord2 = 2'd1;
            end
            default: begin
                w_ord0 = 2'd0;
                w_ord1 = 2'd1;
                w_ord2 = 2'd2;
            end
        endcase
    end

    // First requester in round-robin order wins
    always_comb begin
        w_win     = NO_GNT;
        w_win_vld = 1'b0;
        if (w_req[w_ord0]) begin
            w_win     = w_ord0;
            w_win_vld = 1'b1;
        end else if (w_req[w_ord1]) begin
            w_win     = w_ord1;
            w_win_vld = 1'b1;
        end else if (w_req[w_ord2]) begin
            w_win     = w_ord2;
            w_win_vld = 1'b1;
        end
    end

    // Select the granted master's request signals
    always_comb begin
        w_sel_cyc = 1'b0;
        w_sel_we  = 1'b0;
        w_sel_adr = '0;
        w_sel_dat = '0;
        case (gnt_q)
            2'd0: begin
                w_sel_cyc = m0_cyc_i;
                w_sel_we  = m0_we_i;
                w_sel_adr = m0_adr_i;
                w_sel_dat = m0_dat_i;
            end
            2'd1: begin
                w_sel_cyc = m1_cyc_i;
                w_sel_we  = m1_we_i;
                w_sel_adr = m1_adr_i;
                w_sel_dat = m1_dat_i;
            end
            2'd2: begin
                w_sel_cyc = m2_cyc_i;
                w_sel_we  = m2_we_i;
                w_sel_adr = m2_adr_i;
                w_sel_dat = m2_dat_i;
            end
            default: begin
                w_sel_cyc = 1'b0;
                w_sel_we  = 1'b0;
                w_sel_adr = '0;
                w_sel_dat = '0;
            end
        endcase
    end

    // Next-state, grant, wait counter and completion decode
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        wcnt_d     = wcnt_q;
        w_fire_ack = 1'b0;
        w_fire_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_win_vld) begin
                    state_d = BUSY;
                    gnt_d   = w_win;
                    last_d  = w_win;
                    wcnt_d  = 8'd0;
                end
            end
            BUSY: begin
                if (!w_sel_cyc) begin
                    // Master walked away: drop the cycle silently
                    state_d = DONE;
                end else if (ack_i) begin
                    // Ack beats a coinciding timeout
                    w_fire_ack = !rst;
                    state_d    = DONE;
                end else if (wcnt_q >= TIMEOUT_CNT) begin
                    w_fire_err = !rst;
                    state_d    = DONE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = NO_GNT;
                wcnt_d  = 8'd0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = NO_GNT;
                wcnt_d  = 8'd0;
            end
        endcase
    end

    // State registers; reset leaves master 0 first in line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= NO_GNT;
            last_q  <= 2'd2;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign w_busy    = (state_q == BUSY);
    assign w_gnt_dec = {gnt_q == 2'd2, gnt_q == 2'd1, gnt_q == 2'd0};

    assign cyc_o = w_busy;
    assign stb_o = w_busy;
    assign we_o  = w_busy & w_sel_we;
    assign adr_o = w_busy ? w_sel_adr : '0;
    assign dat_o = w_busy ? w_sel_dat : '0;
    assign gnt_o = gnt_q;

    assign m0_ack_o = w_fire_ack & w_gnt_dec[0];
    assign m1_ack_o = w_fire_ack & w_gnt_dec[1];
    assign m2_ack_o = w_fire_ack & w_gnt_dec[2];

    assign m0_err_o = w_fire_err & w_gnt_dec[0];
    assign m1_err_o = w_fire_err & w_gnt_dec[1];
    assign m2_err_o = w_fire_err & w_gnt_dec[2];

    assign m0_dat_o = (w_fire_ack & w_gnt_dec[0]) ? dat_i : '0;
    assign m1_dat_o = (w_fire_ack & w_gnt_dec[1]) ? dat_i : '0;
    assign m2_dat_o = (w_fire_ack & w_gnt_dec[2]) ? dat_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_data_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wb_data_arbiter
//  Description : Self-checking bench for wb_data_arbiter. Directed cases plus
//                randomized batches; responses checked through a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_data_arbiter;

    localparam int DW  = 32;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          mcyc [3];
    logic          mstb [3];
    logic          mwe  [3];
    logic [DW-1:0] madr [3];
    logic [DW-1:0] mdat [3];
    logic          m0_ack_o, m1_ack_o, m2_ack_o;
    logic          m0_err_o, m1_err_o, m2_err_o;
    logic [DW-1:0] m0_dat_o, m1_dat_o, m2_dat_o;
    logic          cyc_o, stb_o, we_o;
    logic [DW-1:0] adr_o, dat_o;
    logic          ack_i;
    logic [DW-1:0] dat_i;
    logic [1:0]    gnt_o;

    wb_data_arbiter #(.DW(DW), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_cyc_i (mcyc[0]), .m0_stb_i (mstb[0]), .m0_we_i (mwe[0]),
        .m0_adr_i (madr[0]), .m0_dat_i (mdat[0]),
        .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_dat_o (m0_dat_o),
        .m1_cyc_i (mcyc[1]), .m1_stb_i (mstb[1]), .m1_we_i (mwe[1]),
        .m1_adr_i (madr[1]), .m1_dat_i (mdat[1]),
        .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_dat_o (m1_dat_o),
        .m2_cyc_i (mcyc[2]), .m2_stb_i (mstb[2]), .m2_we_i (mwe[2]),
        .m2_adr_i (madr[2]), .m2_dat_i (mdat[2]),
        .m2_ack_o (m2_ack_o), .m2_err_o (m2_err_o), .m2_dat_o (m2_dat_o),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .we_o     (we_o),
        .adr_o    (adr_o),
        .dat_o    (dat_o),
        .ack_i    (ack_i),
        .dat_i    (dat_i),
        .gnt_o    (gnt_o)
    );

    always #5 clk = ~clk;

    // Expected master-side response
    typedef struct {
        int          m;
        bit          is_err;
        logic [31:0] data;
        int          offset;   // cycles after the first stb_o cycle
    } exp_t;

    // One master transaction plus the slave behaviour chosen for it
    typedef struct {
        int          m;
        bit          we;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          dly;      // 0 = slave never acks
        logic [31:0] rdat;
    } txn_t;

    exp_t sb[$];
    txn_t plan[$];
    txn_t mt [3][4];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;
    bit   done_flag [3];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%h required 0x%h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [31:0] dat_of(input int n);
        case (n)
            0:       return m0_dat_o;
            1:       return m1_dat_o;
            default: return m2_dat_o;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- response monitor ----------------
    exp_t       mx;
    logic [2:0] ma, me;
    logic       prev_stb = 1'b0;
    int         busy_start = 0;
    logic [31:0] other_dat;

    always @(negedge clk) begin
        if (stb_o && !prev_stb) busy_start = cyc_cnt;
        prev_stb = stb_o;
        ma = {m2_ack_o, m1_ack_o, m0_ack_o};
        me = {m2_err_o, m1_err_o, m0_err_o};
        if (|(ma | me)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_response: actual ack=%b err=%b required none", ma, me);
            end else begin
                mx = sb.pop_front();
                check("resp_ack", {29'd0, ma}, mx.is_err ? 32'd0 : (32'd1 << mx.m));
                check("resp_err", {29'd0, me}, mx.is_err ? (32'd1 << mx.m) : 32'd0);
                check("resp_dat", dat_of(mx.m), mx.is_err ? 32'd0 : mx.data);
                other_dat = (mx.m == 0 ? 32'd0 : m0_dat_o) |
                            (mx.m == 1 ? 32'd0 : m1_dat_o) |
                            (mx.m == 2 ? 32'd0 : m2_dat_o);
                check("resp_other_dat", other_dat, 32'd0);
                check("resp_latency", 32'(cyc_cnt - busy_start), 32'(mx.offset));
                done_flag[mx.m] = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic idle_inputs();
        for (int n = 0; n < 3; n++) begin
            mcyc[n] = 1'b0; mstb[n] = 1'b0; mwe[n] = 1'b0;
            madr[n] = '0;   mdat[n] = '0;
            done_flag[n] = 1'b0;
        end
        ack_i = 1'b0;
        dat_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_exp(input int m, input bit is_err, input logic [31:0] d, input int off);
        exp_t e;
        e.m = m; e.is_err = is_err; e.data = d; e.offset = off;
        sb.push_back(e);
    endtask

    // One transaction, slave acks the cycle after it first sees stb
    task automatic single(input int m, input bit we, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic [31:0] rdat);
        do_reset();
        mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = we; madr[m] = adr; mdat[m] = wdat;
        push_exp(m, 1'b0, rdat, 1);
        tick();                                     // T+1
        check("single_stb",  {31'd0, stb_o}, 32'd1);
        check("single_gnt",  {30'd0, gnt_o}, 32'(m));
        check("single_we",   {31'd0, we_o},  {31'd0, we});
        check("single_adr",  adr_o, adr);
        check("single_wdat", dat_o, wdat);
        tick();                                     // T+2
        ack_i = 1'b1; dat_i = rdat;
        tick();                                     // T+3
        ack_i = 1'b0; dat_i = '0;
        check("single_stb_drop", {31'd0, stb_o}, 32'd0);
        mcyc[m] = 1'b0; mstb[m] = 1'b0;
        tick();                                     // T+4
        check("single_idle_gnt", {30'd0, gnt_o}, 32'd3);
    endtask

    // Masters hold queued transactions back to back; reference grant
    // order comes from a round-robin over masters with work remaining.
    task automatic run_batch(input int c0, input int c1, input int c2, input bit rnd);
        int   cnt [3];
        int   rem [3];
        int   pos [3];
        int   last, w, r, budget, s_idx;
        bit   s_active, all_done;
        txn_t t, cur;
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2;
        for (int n = 0; n < 3; n++) begin
            rem[n] = cnt[n];
            pos[n] = 0;
            for (int k = 0; k < cnt[n]; k++) begin
                mt[n][k].m    = n;
                mt[n][k].we   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                mt[n][k].adr  = rnd ? $urandom : 32'h100 * (n + 1) + k;
                mt[n][k].wdat = rnd ? $urandom : 32'h0;
            end
        end
        last = 2;
        while (rem[0] + rem[1] + rem[2] > 0) begin
            w = -1;
            for (int i = 1; i <= 3; i++) begin
                if (w < 0 && rem[(last + i) % 3] > 0) w = (last + i) % 3;
            end
            t = mt[w][cnt[w] - rem[w]];
            rem[w]--;
            last = w;
            if (rnd) begin
                r = $urandom_range(0, 9);
                t.dly = (r == 0) ? 0 : (r == 1) ? TMO : 1 + (r % 3);
            end else begin
                t.dly = 1;
            end
            t.rdat = $urandom;
            plan.push_back(t);
            if (t.dly == 0) push_exp(w, 1'b1, 32'd0, TMO);
            else            push_exp(w, 1'b0, t.rdat, t.dly);
        end

        do_reset();
        s_active = 1'b0;
        s_idx    = 0;
        cur      = t;
        all_done = 1'b0;
        budget   = 0;
        while (!all_done && budget < 1500) begin
            for (int n = 0; n < 3; n++) begin
                if (done_flag[n]) begin
                    pos[n]++;
                    done_flag[n] = 1'b0;
                end
                if (pos[n] < cnt[n]) begin
                    mcyc[n] = 1'b1; mstb[n] = 1'b1;
                    mwe[n]  = mt[n][pos[n]].we;
                    madr[n] = mt[n][pos[n]].adr;
                    mdat[n] = mt[n][pos[n]].wdat;
                end else begin
                    mcyc[n] = 1'b0; mstb[n] = 1'b0;
                end
            end
            if (stb_o) begin
                if (!s_active) begin
                    s_active = 1'b1;
                    s_idx    = 0;
                    if (plan.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL batch_extra_grant: actual gnt=%0d required no grant", gnt_o);
                    end else begin
                        cur = plan.pop_front();
                        check("batch_gnt",  {30'd0, gnt_o}, 32'(cur.m));
                        check("batch_we",   {31'd0, we_o},  {31'd0, cur.we});
                        check("batch_adr",  adr_o, cur.adr);
                        check("batch_wdat", dat_o, cur.wdat);
                    end
                end else begin
                    s_idx++;
                end
                ack_i = (cur.dly != 0) && (s_idx == cur.dly);
                dat_i = ack_i ? cur.rdat : $urandom;
            end else begin
                s_active = 1'b0;
                ack_i    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                dat_i    = $urandom;
            end
            all_done = (pos[0] >= cnt[0]) && (pos[1] >= cnt[1]) && (pos[2] >= cnt[2]) &&
                       (sb.size() == 0) && (plan.size() == 0);
            tick();
            budget++;
        end
        if (!all_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL batch_timeout: actual %0d responses outstanding required 0", sb.size());
            sb.delete();
            plan.delete();
        end
        idle_inputs();
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int to;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        // Reset state
        check("rst_gnt",   {30'd0, gnt_o}, 32'd3);
        check("rst_ctl",   {29'd0, cyc_o, stb_o, we_o}, 32'd0);
        check("rst_bus",   adr_o | dat_o, 32'd0);
        check("rst_resp",  {26'd0, m0_ack_o, m1_ack_o, m2_ack_o, m0_err_o, m1_err_o, m2_err_o}, 32'd0);
        check("rst_mdat",  m0_dat_o | m1_dat_o | m2_dat_o, 32'd0);

        // Single read by master 0
        single(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

        // All three request from reset: 0,1,2,0
        run_batch(2, 1, 1, 1'b0);

        // Write by master 2
        single(2, 1'b1, 32'h40, 32'h12345678, 32'h0);

        // Timeout on master 1
        do_reset();
        mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h80;
        push_exp(1, 1'b1, 32'd0, TMO);
        to = 0;
        while (!done_flag[1] && to < 40) begin
            tick();
            to++;
        end
        check("tmo_seen", {31'd0, done_flag[1]}, 32'd1);
        check("tmo_stb_drop", {31'd0, stb_o}, 32'd0);
        mcyc[1] = 1'b0; mstb[1] = 1'b0;
        tick();
        check("tmo_idle_gnt", {30'd0, gnt_o}, 32'd3);
        tick();
        tick();

        // Abort: master 0 drops cyc while the slave acks
        do_reset();
        mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h20;
        tick();
        check("abort_stb", {31'd0, stb_o}, 32'd1);
        tick();
        mcyc[0] = 1'b0; ack_i = 1'b1; dat_i = 32'hCAFEF00D;
        #1;
        check("abort_no_ack", {30'd0, m0_ack_o, m0_err_o}, 32'd0);
        check("abort_no_dat", m0_dat_o, 32'd0);
        tick();
        ack_i = 1'b0; mstb[0] = 1'b0;
        check("abort_done_stb", {31'd0, stb_o}, 32'd0);
        tick();
        check("abort_idle_gnt", {30'd0, gnt_o}, 32'd3);

        // Reset while BUSY, late ack ignored
        do_reset();
        mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h30;
        tick();
        check("rstbusy_stb", {31'd0, stb_o}, 32'd1);
        rst = 1'b1;
        tick();
        check("rstbusy_stb_drop", {31'd0, stb_o}, 32'd0);
        check("rstbusy_gnt", {30'd0, gnt_o}, 32'd3);
        rst = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
        ack_i = 1'b1; dat_i = 32'h55AA55AA;
        #1;
        check("rstbusy_no_ack", {30'd0, m1_ack_o, m1_err_o}, 32'd0);
        tick();
        ack_i = 1'b0;
        tick();

        // Randomized batches
        for (int b = 0; b < 5; b++) begin
            run_batch($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), 1'b1);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/wb_data_arbiter.md
WB_DATA_ARBITER -- requirements
Module: wb_data_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data and address width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for slave ack before aborting (1..255).
REQ-003 The block SHALL have the port clk, input, 1 bit: clock, with all state updated on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 For each n in {0,1,2}, the block SHALL have the input ports mn_cyc_i, mn_stb_i and mn_we_i, each 1 bit, forming master n's Wishbone classic request.
REQ-006 For each n in {0,1,2}, the block SHALL have the input ports mn_adr_i and mn_dat_i, each DW bits, carrying master n's address and write data.
REQ-007 For each n in {0,1,2}, the block SHALL have the output ports mn_ack_o and mn_err_o, each 1 bit, carrying master n's completion and timeout error.
REQ-008 For each n in {0,1,2}, the block SHALL have the output port mn_dat_o, DW bits, carrying master n's read data.
REQ-009 The block SHALL have the output ports cyc_o, stb_o and we_o, each 1 bit, forming the shared slave (data RAM) request.
REQ-010 The block SHALL have the output ports adr_o and dat_o, each DW bits, carrying the slave address and write data.
REQ-011 The block SHALL have the input ports ack_i (1 bit) and dat_i (DW bits), carrying the slave acknowledge and read data; the slave asserts ack_i one cycle after it samples cyc&stb.
REQ-012 The block SHALL have the output port gnt_o, 2 bits, giving the current grant index; the value 3 means no grant.

Function
REQ-013 A master n SHALL be requesting exactly when mn_cyc_i & mn_stb_i is high.
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 In IDLE, if any master is requesting, the FSM SHALL register the winner into gnt, load the wait counter with 0, and move to BUSY on the next cycle; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin from a 2-bit last-grant pointer, searching in the order last+1, last+2, last+3 (mod 3); the pointer SHALL update to the winner when the grant is taken.
REQ-017 cyc_o and stb_o SHALL equal (state==BUSY), combinationally decoded from registered state.
REQ-018 we_o, adr_o and dat_o SHALL be multiplexed from the granted master while in BUSY, and SHALL be 0 otherwise.
REQ-019 In BUSY, when ack_i=1, the block SHALL combinationally set mn_ack_o=1 and mn_dat_o=dat_i for the granted master n in the same cycle, and the state SHALL go to DONE on the next cycle, so that stb_o drops and no duplicate slave ack is generated.
REQ-020 DONE SHALL last exactly one cycle, return to IDLE with gnt=3, and assert no ack; this guarantees one dead cycle so the requester can deassert stb.
REQ-021 In BUSY without ack_i, the wait counter SHALL increment by one per cycle.
REQ-022 When the wait counter reaches TIMEOUT, the block SHALL pulse mn_err_o for one cycle to the granted master and go to DONE; mn_ack_o SHALL stay 0.
REQ-023 If ack_i and the timeout coincide, the ack SHALL take precedence and err SHALL not be asserted.
REQ-024 If the granted master drops mn_cyc_i while in BUSY, the transaction SHALL be aborted: the state SHALL go to DONE on the next cycle, any ack_i in that cycle SHALL NOT be forwarded, and no err SHALL be raised.
REQ-025 Non-granted masters SHALL always see ack=0, err=0 and dat_o=0.
REQ-026 Ack_i received in IDLE or DONE SHALL be ignored.
REQ-027 The minimum latency SHALL be: request seen at cycle T (IDLE), stb_o at T+1, master ack at T+2, and the next grant able to be taken at T+4.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set state=IDLE, gnt=3, last-grant pointer=2 (so master 0 wins first), and wait counter=0.
REQ-029 After reset, all outputs SHALL be 0 except gnt_o, which SHALL be 3.
REQ-030 A reset asserted during BUSY SHALL abandon the transaction with no ack or err; a late ack_i SHALL be ignored.

Verification
REQ-031 The bench SHALL cover a single read: m0 requests read at adr 0x10, and the slave acks at the next cycle with dat_i=0xDEADBEEF -> m0_ack_o=1 with m0_dat_o=0xDEADBEEF at T+2, and stb_o low at T+3.
REQ-032 The bench SHALL cover simultaneous requests: all three masters hold requests from reset -> grants in the order 0,1,2,0, with each ack delivered only to its owner.
REQ-033 The bench SHALL cover a write: m2 writes 0x12345678 to adr 0x40 -> we_o=1, adr_o=0x40 and dat_o=0x12345678 in the BUSY cycle; m2_ack_o=1.
REQ-034 The bench SHALL cover a timeout: the slave never acks with TIMEOUT=15 -> m1_err_o pulses once 15 cycles after the BUSY entry, then IDLE with gnt_o=3.
REQ-035 The bench SHALL cover an abort: m0 drops cyc in BUSY while ack_i=1 in the same cycle -> no m0_ack_o, and state passes through DONE to IDLE.
REQ-036 The bench SHALL cover reset in BUSY: rst is asserted while stb_o=1 -> on the next cycle stb_o=0 and gnt_o=3, and the following ack_i is ignored.
